ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter.
- The existing keyboard receive path only listens. This block drives commands to the keyboard over the same open-drain clock/data pair, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sequence: inhibit the bus, request-to-send, then shift one byte with odd parity on device-generated clock edges, then check the device ACK.
- Asserts busy while active so the receive path can ignore bus activity.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2_clk is held low before RTS (100 us at 50 MHz).
- RTS_CYCLES, 50: clk cycles data is held low with clock still low, before clock release.
- TIMEOUT_CYCLES, 750000: max clk cycles between consecutive device falling edges, and from clock release to first edge (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz board clock)
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  send request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: byte sent and ACK received
- err  out  1  one-cycle pulse: timeout or missing ACK
- Keyb_clk  in  1  PS/2 clock line as read from pad
- Keyboard_data  in  1  PS/2 data line as read from pad
- ps2_clk_drv  out  1  1 = pull clock line low (pad is open-drain)
- ps2_data_drv  out  1  1 = pull data line low

Behaviour:
- Reset (async, any state):
  - state = IDLE.
  - ps2_clk_drv = 0, ps2_data_drv = 0 (both lines released immediately, mid-frame too).
  - tx_ready = 1, busy = 0, done = 0, err = 0.
  - Counters and shift register cleared.
- Input synchronisation:
  - Keyb_clk and Keyboard_data each pass through 2 flops.
  - Falling edge fe = sync_clk_prev & ~sync_clk.
  - fe is therefore 3 clk after the pad edge.
- Accept: on tx_valid && tx_ready, latch tx_data into shift reg and compute parity = ~^tx_data (odd). tx_valid is ignored while busy; no queueing.
- INHIBIT: ps2_clk_drv = 1 for exactly INHIBIT_CYCLES cycles.
- RTS: ps2_data_drv = 1 (start bit 0) with ps2_clk_drv still 1, for RTS_CYCLES cycles. Then ps2_clk_drv = 0, bit counter = 0, timeout counter cleared.
- SHIFT: on each fe, increment bit counter n:
  - n = 1..8: ps2_data_drv = ~data[n-1], LSB first.
  - n = 9: ps2_data_drv = ~parity.
  - n = 10: ps2_data_drv = 0 (stop bit 1).
  - n = 11: sample sync data. If 0, go to WAIT_IDLE with ack_ok; if 1, go to WAIT_IDLE with ack_bad.
- WAIT_IDLE: wait until sync clk = 1 and sync data = 1 (device released the bus). Then go to IDLE and pulse done (ack_ok) or err (ack_bad).
- Timeout:
  - Counter runs in SHIFT and WAIT_IDLE and clears on every fe (WAIT_IDLE: clears on entry).
  - On reaching TIMEOUT_CYCLES: release both drives the same cycle, pulse err, go to IDLE.
- tx_ready rises the same cycle done or err pulses. A new tx_valid is accepted on the next cycle.
- done and err are never high together.
- No output glitches: drive outputs are registered.

Test Plan:
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs -> ps2_clk_drv low for 5000 cycles; start bit seen; data bits on line 1,0,1,1,0,1,1,1 (LSB first); parity 1; stop 1; done pulses once; err stays 0; tx_ready back to 1.
- Send 0xF4, then 0x01 back-to-back (second tx_valid held during the first) -> second accepted only after first done. Parities are 0 and 0; line sequences match LSB-first bytes.
- Device model never clocks after clock release -> err pulses exactly TIMEOUT_CYCLES cycles after release; both drives 0; no done.
- Device clocks all 11 edges but leaves data high on edge 11 -> err pulse after bus idle; done stays 0.
- Assert rst_n low while n = 5 in SHIFT -> ps2_clk_drv and ps2_data_drv go 0 asynchronously (before next clk edge); after release, tx_ready = 1 and busy = 0.
- tx_valid pulsed while busy with 0x55 -> ignored; only the original byte appears on the line.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, shifts one
// byte plus odd parity on device clock edges, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 50,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       Keyb_clk,
  input  logic       Keyboard_data,
  output logic       ps2_clk_drv,
  output logic       ps2_data_drv
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + INHIBIT_CYCLES + RTS_CYCLES + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity;
  logic             ack_ok;

  logic sync_clk_meta, sync_clk, sync_clk_prev;
  logic sync_data_meta, sync_data;
  logic fe;

  // Pad inputs are asynchronous to clk; the idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_clk_meta  <= 1'b1;
      sync_clk       <= 1'b1;
      sync_clk_prev  <= 1'b1;
      sync_data_meta <= 1'b1;
      sync_data      <= 1'b1;
    end else begin
      sync_clk_meta  <= Keyb_clk;
      sync_clk       <= sync_clk_meta;
      sync_clk_prev  <= sync_clk;
      sync_data_meta <= Keyboard_data;
      sync_data      <= sync_data_meta;
    end
  end

  assign fe       = sync_clk_prev & ~sync_clk;
  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity       <= 1'b0;
      ack_ok       <= 1'b0;
      ps2_clk_drv  <= 1'b0;
      ps2_data_drv <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_reg   <= tx_data;
            parity      <= ~^tx_data;
            ps2_clk_drv <= 1'b1;
            cnt         <= '0;
            state       <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (cnt == INHIBIT_LAST) begin
            cnt          <= '0;
            ps2_data_drv <= 1'b1;
            state        <= ST_RTS;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RTS: begin
          if (cnt == RTS_LAST) begin
            cnt         <= '0;
            bit_cnt     <= '0;
            ps2_clk_drv <= 1'b0;
            state       <= ST_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          // bit_cnt holds the number of edges seen before this one.
          if (fe) begin
            cnt     <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt <= 4'd7) begin
              ps2_data_drv <= ~shift_reg[0];
              shift_reg    <= {1'b0, shift_reg[7:1]};
            end else if (bit_cnt == 4'd8) begin
              ps2_data_drv <= ~parity;
            end else if (bit_cnt == 4'd9) begin
              ps2_data_drv <= 1'b0;
            end else begin
              ack_ok <= ~sync_data;
              state  <= ST_WAIT_IDLE;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            cnt          <= '0;
            ps2_clk_drv  <= 1'b0;
            ps2_data_drv <= 1'b0;
            err          <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (sync_clk && sync_data) begin
            cnt   <= '0;
            done  <= ack_ok;
            err   <= ~ack_ok;
            state <= ST_IDLE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt          <= '0;
            ps2_clk_drv  <= 1'b0;
            ps2_data_drv <= 1'b0;
            err          <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ps2_clk_drv  <= 1'b0;
          ps2_data_drv <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a small PS/2 device model,
// table-driven frames plus hand-written timeout, back-to-back and reset sequences.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int RTS  = 6;
  localparam int TMO  = 400;
  localparam int HALF = 20;
  localparam int FRAME_BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_drv, ps2_data_drv;
  logic       kb_clk, kb_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int n_vec = 0;
  int n_miscmp = 0;

  assign kb_clk  = ~(ps2_clk_drv | dev_clk_low);
  assign kb_data = ~(ps2_data_drv | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .Keyb_clk(kb_clk),
    .Keyboard_data(kb_data),
    .ps2_clk_drv(ps2_clk_drv),
    .ps2_data_drv(ps2_data_drv)
  );

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       parity;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  typedef struct {
    int inh;
    int rts;
    int rel_cyc;
    int err_cyc;
    int done_n;
    int err_n;
    int both;
    int drv_at_err;
    int finished;
  } obs_t;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Device side: waits for the host to release the clock with the start bit
  // down, then clocks `edges` falling edges, sampling the line before each one.
  task automatic device_run(input logic ack, input int edges,
                            output logic [10:0] bits, output logic ok);
    int w;
    ok = 1'b0;
    bits = '0;
    w = 0;
    while (!(busy && !ps2_clk_drv && ps2_data_drv) && w < INH + RTS + 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= INH + RTS + 20) return;
    for (int k = 0; k < edges; k++) begin
      repeat (HALF) @(negedge clk);
      bits[k] = kb_data;
      if (k == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (4) @(negedge clk);
    dev_data_low = 1'b0;
    ok = 1'b1;
  endtask

  // Host side observer: must be entered on the negedge where tx_valid was raised.
  task automatic watch_frame(input logic hold_valid, input logic [7:0] next_data,
                             input int poke_at, output obs_t obs);
    int  cyc;
    logic seen_drv;
    obs = '{default: 0};
    obs.rel_cyc = -1;
    obs.err_cyc = -1;
    cyc = 0;
    seen_drv = 1'b0;
    while (cyc < FRAME_BUDGET) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (hold_valid) tx_data = next_data;
        else tx_valid = 1'b0;
      end
      if (poke_at != 0 && cyc == poke_at) begin
        tx_data = 8'h55;
        tx_valid = 1'b1;
      end
      if (poke_at != 0 && cyc == poke_at + 1) tx_valid = 1'b0;
      if (ps2_clk_drv && !ps2_data_drv) obs.inh++;
      if (ps2_clk_drv && ps2_data_drv) obs.rts++;
      if (ps2_clk_drv) seen_drv = 1'b1;
      else if (seen_drv && obs.rel_cyc < 0) obs.rel_cyc = cyc;
      if (done) obs.done_n++;
      if (err) begin
        obs.err_n++;
        obs.err_cyc = cyc;
        obs.drv_at_err = int'(ps2_clk_drv | ps2_data_drv);
      end
      if (done && err) obs.both++;
      if (tx_ready) begin
        obs.finished = 1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input obs_t obs, input logic [10:0] bits,
                             input logic dev_ok, input logic [7:0] data, input logic par,
                             input logic exp_done, input logic exp_err);
    logic [10:0] exp_frame;
    exp_frame = {1'b1, par, data, 1'b0};
    checkOutput({tag, "_finished"}, obs.finished, 1);
    checkOutput({tag, "_dev_ok"}, int'(dev_ok), 1);
    checkOutput({tag, "_inhibit_len"}, obs.inh, INH);
    checkOutput({tag, "_rts_len"}, obs.rts, RTS);
    checkOutput({tag, "_line_bits"}, int'(bits), int'(exp_frame));
    checkOutput({tag, "_done_pulses"}, obs.done_n, int'(exp_done));
    checkOutput({tag, "_err_pulses"}, obs.err_n, int'(exp_err));
    checkOutput({tag, "_done_err_overlap"}, obs.both, 0);
  endtask

  task automatic applyStimulus(input vec_t v, input int poke_at,
                               output obs_t obs, output logic [10:0] bits, output logic ok);
    @(negedge clk);
    tx_data = v.data;
    tx_valid = 1'b1;
    fork
      device_run(v.ack, 11, bits, ok);
      watch_frame(1'b0, 8'h00, poke_at, obs);
    join
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[5];
    obs_t        obs, obs2;
    logic [10:0] bits, bits2;
    logic        ok, ok2;
    int          busy_seen;

    vecs[0] = '{data: 8'hED, ack: 1'b1, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[1] = '{data: 8'hF4, ack: 1'b1, parity: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    vecs[2] = '{data: 8'hFF, ack: 1'b1, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[3] = '{data: 8'h00, ack: 1'b1, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    vecs[4] = '{data: 8'hA6, ack: 1'b0, parity: 1'b1, exp_done: 1'b0, exp_err: 1'b1};

    #3;
    checkOutput("reset_tx_ready", int'(tx_ready), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done_err", int'({done, err}), 0);
    checkOutput("reset_drives", int'({ps2_clk_drv, ps2_data_drv}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], 0, obs, bits, ok);
      check_frame($sformatf("vec%0d", i), obs, bits, ok, vecs[i].data, vecs[i].parity,
                  vecs[i].exp_done, vecs[i].exp_err);
      repeat (5) @(negedge clk);
    end

    // Back-to-back: second request held high during the first frame.
    @(negedge clk);
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    fork
      device_run(1'b1, 11, bits, ok);
      watch_frame(1'b1, 8'h01, 0, obs);
    join
    fork
      device_run(1'b1, 11, bits2, ok2);
      watch_frame(1'b0, 8'h00, 0, obs2);
    join
    check_frame("b2b_first", obs, bits, ok, 8'hF4, 1'b0, 1'b1, 1'b0);
    check_frame("b2b_second", obs2, bits2, ok2, 8'h01, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);

    // Request pulsed mid-frame must be dropped.
    applyStimulus('{data: 8'hED, ack: 1'b1, parity: 1'b1, exp_done: 1'b1, exp_err: 1'b0},
                  150, obs, bits, ok);
    check_frame("poke", obs, bits, ok, 8'hED, 1'b1, 1'b1, 1'b0);
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    checkOutput("poke_no_restart", busy_seen, 0);

    // Silent device: timeout measured from clock release.
    @(negedge clk);
    tx_data = 8'hAB;
    tx_valid = 1'b1;
    watch_frame(1'b0, 8'h00, 0, obs);
    checkOutput("tmo_finished", obs.finished, 1);
    checkOutput("tmo_err_pulses", obs.err_n, 1);
    checkOutput("tmo_done_pulses", obs.done_n, 0);
    checkOutput("tmo_latency", obs.err_cyc - obs.rel_cyc, TMO);
    checkOutput("tmo_drives_at_err", obs.drv_at_err, 0);
    repeat (5) @(negedge clk);

    // Reset during INHIBIT releases the clock line without waiting for clk.
    @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_inh_pre_clk_drv", int'(ps2_clk_drv), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_inh_clk_drv", int'(ps2_clk_drv), 0);
    checkOutput("rst_inh_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset after the fifth device edge: data line is driven for data[4]=0.
    @(negedge clk);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    fork
      device_run(1'b0, 5, bits, ok);
      begin
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    checkOutput("rst_shift_dev_ok", int'(ok), 1);
    checkOutput("rst_shift_pre_busy", int'(busy), 1);
    checkOutput("rst_shift_pre_data_drv", int'(ps2_data_drv), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_shift_drives", int'({ps2_clk_drv, ps2_data_drv}), 0);
    checkOutput("rst_shift_done_err", int'({done, err}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_shift_tx_ready", int'(tx_ready), 1);
    checkOutput("rst_shift_busy", int'(busy), 0);

    // The bus must still work after an aborted frame.
    repeat (5) @(negedge clk);
    applyStimulus(vecs[1], 0, obs, bits, ok);
    check_frame("after_rst", obs, bits, ok, vecs[1].data, vecs[1].parity, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
